// File: rtl/wb_stage_if.sv
// M-to-W pipeline bundle for the write-back stage, plus the register-file
// write port and the retired-instruction count that the stage drives.
interface wb_stage_if;
    logic        M_Valid;
    logic [31:0] M_PC;
    logic        M_RegWrite;
    logic [4:0]  M_WAddr;
    logic [31:0] M_ALURes;
    logic [31:0] M_MemData;
    logic [1:0]  M_ByteOff;
    logic [2:0]  M_LoadType;
    logic [1:0]  M_WBSel;
    logic        Stall;
    logic        Flush;
    logic        W_Valid;
    logic        W_RegWrite;
    logic [4:0]  W_WAddr;
    logic [31:0] W_WriteData;
    logic [31:0] W_PC;
    logic [31:0] W_Retired;

    modport master (
        output M_Valid, M_PC, M_RegWrite, M_WAddr, M_ALURes, M_MemData,
               M_ByteOff, M_LoadType, M_WBSel, Stall, Flush,
        input  W_Valid, W_RegWrite, W_WAddr, W_WriteData, W_PC, W_Retired
    );

    modport slave (
        input  M_Valid, M_PC, M_RegWrite, M_WAddr, M_ALURes, M_MemData,
               M_ByteOff, M_LoadType, M_WBSel, Stall, Flush,
        output W_Valid, W_RegWrite, W_WAddr, W_WriteData, W_PC, W_Retired
    );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage register: load extension and source select ahead of the
// W flops, which are the only drivers of the register-file write port.
module wb_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    wb_stage_if.slave   bus
);

    logic        valid_q,    valid_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  waddr_q,    waddr_d;
    logic [31:0] wdata_q,    wdata_d;
    logic [31:0] pc_q,       pc_d;
    logic [31:0] retired_q,  retired_d;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic [31:0] wb_src;
    logic        write_en;

    always_comb begin
        case (bus.M_ByteOff)
            2'd0:    byte_sel = bus.M_MemData[7:0];
            2'd1:    byte_sel = bus.M_MemData[15:8];
            2'd2:    byte_sel = bus.M_MemData[23:16];
            default: byte_sel = bus.M_MemData[31:24];
        endcase
        half_sel = bus.M_ByteOff[1] ? bus.M_MemData[31:16] : bus.M_MemData[15:0];

        case (bus.M_LoadType)
            3'd1:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'd2:    load_ext = {24'd0, byte_sel};
            3'd3:    load_ext = {{16{half_sel[15]}}, half_sel};
            3'd4:    load_ext = {16'd0, half_sel};
            default: load_ext = bus.M_MemData;
        endcase

        case (bus.M_WBSel)
            2'd1:    wb_src = load_ext;
            2'd2:    wb_src = bus.M_PC + 32'd8;
            default: wb_src = bus.M_ALURes;
        endcase

        // $0 is hardwired: the write is dropped but the address is still recorded
        write_en = bus.M_RegWrite && (bus.M_WAddr != 5'd0);
    end

    always_comb begin
        valid_d    = valid_q;
        regwrite_d = regwrite_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        retired_d  = retired_q;

        if (bus.Flush || (!bus.Stall && !bus.M_Valid)) begin
            valid_d    = 1'b0;
            regwrite_d = 1'b0;
            waddr_d    = 5'd0;
            wdata_d    = 32'd0;
            pc_d       = RESET_PC;
        end else if (!bus.Stall) begin
            valid_d    = 1'b1;
            regwrite_d = write_en;
            waddr_d    = bus.M_WAddr;
            wdata_d    = write_en ? wb_src : 32'd0;
            pc_d       = bus.M_PC;
            retired_d  = retired_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            waddr_q    <= 5'd0;
            wdata_q    <= 32'd0;
            pc_q       <= RESET_PC;
            retired_q  <= 32'd0;
        end else begin
            valid_q    <= valid_d;
            regwrite_q <= regwrite_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
        end
    end

    assign bus.W_Valid     = valid_q;
    assign bus.W_RegWrite  = regwrite_q;
    assign bus.W_WAddr     = waddr_q;
    assign bus.W_WriteData = wdata_q;
    assign bus.W_PC        = pc_q;
    assign bus.W_Retired   = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: load extension, source select, $0 suppression,
// stall/flush priority, async reset and retired-counter wrap.
module tb_wb_stage;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    wb_stage_if bus ();

    wb_stage #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive_m(input logic v, input logic [31:0] pc, input logic rw,
                           input logic [4:0] wa, input logic [31:0] alu,
                           input logic [31:0] mem, input logic [1:0] off,
                           input logic [2:0] lt, input logic [1:0] sel);
        bus.M_Valid    = v;
        bus.M_PC       = pc;
        bus.M_RegWrite = rw;
        bus.M_WAddr    = wa;
        bus.M_ALURes   = alu;
        bus.M_MemData  = mem;
        bus.M_ByteOff  = off;
        bus.M_LoadType = lt;
        bus.M_WBSel    = sel;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_w(input string tag, input logic v, input logic rw,
                           input logic [4:0] wa, input logic [31:0] wd,
                           input logic [31:0] pc, input logic [31:0] ret);
        check({tag, ".valid"},   {31'd0, bus.W_Valid},    {31'd0, v});
        check({tag, ".regwr"},   {31'd0, bus.W_RegWrite}, {31'd0, rw});
        check({tag, ".waddr"},   {27'd0, bus.W_WAddr},    {27'd0, wa});
        check({tag, ".wdata"},   bus.W_WriteData,         wd);
        check({tag, ".pc"},      bus.W_PC,                pc);
        check({tag, ".retired"}, bus.W_Retired,           ret);
    endtask

    localparam logic [31:0] MEMW = 32'h8081_8283;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        drive_m(1'b1, 32'h0000_3abc, 1'b1, 5'd3, 32'h1111_1111, MEMW, 2'd0, 3'd0, 2'd0);

        repeat (3) @(posedge clk);
        #1;
        check_w("reset", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        drive_m(1'b0, 32'h0, 1'b0, 5'd0, 32'd0, 32'd0, 2'd0, 3'd0, 2'd0);
        step();
        check_w("idle", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd0);

        // Loads from the same word at various offsets and types
        @(negedge clk);
        drive_m(1'b1, 32'h0000_3000, 1'b1, 5'd5, 32'hAAAA_AAAA, MEMW, 2'd1, 3'd1, 2'd1);
        step();
        check_w("lb_off1", 1'b1, 1'b1, 5'd5, 32'hFFFF_FF82, 32'h0000_3000, 32'd1);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3004, 1'b1, 5'd6, 32'hAAAA_AAAA, MEMW, 2'd3, 3'd2, 2'd1);
        step();
        check_w("lbu_off3", 1'b1, 1'b1, 5'd6, 32'h0000_0080, 32'h0000_3004, 32'd2);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3008, 1'b1, 5'd7, 32'hAAAA_AAAA, MEMW, 2'd2, 3'd3, 2'd1);
        step();
        check_w("lh_off2", 1'b1, 1'b1, 5'd7, 32'hFFFF_8081, 32'h0000_3008, 32'd3);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_300c, 1'b1, 5'd8, 32'hAAAA_AAAA, MEMW, 2'd0, 3'd4, 2'd1);
        step();
        check_w("lhu_off0", 1'b1, 1'b1, 5'd8, 32'h0000_8283, 32'h0000_300c, 32'd4);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3020, 1'b1, 5'd9, 32'hAAAA_AAAA, 32'h0123_F0E1, 2'd1, 3'd3, 2'd1);
        step();
        check("lh_off1_ignores_bit0", bus.W_WriteData, 32'hFFFF_F0E1);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3024, 1'b1, 5'd9, 32'hAAAA_AAAA, MEMW, 2'd1, 3'd6, 2'd1);
        step();
        check("lt6_as_lw", bus.W_WriteData, MEMW);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3010, 1'b1, 5'd31, 32'hAAAA_AAAA, MEMW, 2'd0, 3'd0, 2'd2);
        // outputs must not follow M inputs until the edge
        #1;
        check("no_comb_path", bus.W_WriteData, MEMW);
        step();
        check_w("jal", 1'b1, 1'b1, 5'd31, 32'h0000_3018, 32'h0000_3010, 32'd7);

        @(negedge clk);
        drive_m(1'b1, 32'hFFFF_FFFC, 1'b1, 5'd1, 32'hAAAA_AAAA, MEMW, 2'd0, 3'd0, 2'd2);
        step();
        check("pc8_wrap", bus.W_WriteData, 32'h0000_0004);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3014, 1'b1, 5'd0, 32'h1234_5678, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        check_w("addu_r0", 1'b1, 1'b0, 5'd0, 32'd0, 32'h0000_3014, 32'd9);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_3018, 1'b1, 5'd12, 32'hDEAD_BEEF, MEMW, 2'd0, 3'd1, 2'd3);
        step();
        check_w("sel3_alu", 1'b1, 1'b1, 5'd12, 32'hDEAD_BEEF, 32'h0000_3018, 32'd10);

        @(negedge clk);
        drive_m(1'b1, 32'h0000_301c, 1'b0, 5'd13, 32'hCAFE_F00D, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        check_w("nowrite", 1'b1, 1'b0, 5'd13, 32'd0, 32'h0000_301c, 32'd11);

        // Stall two cycles with a different instruction waiting in M
        @(negedge clk);
        bus.Stall = 1'b1;
        drive_m(1'b1, 32'h0000_3040, 1'b1, 5'd20, 32'h5555_5555, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        check_w("stall1", 1'b1, 1'b0, 5'd13, 32'd0, 32'h0000_301c, 32'd11);
        step();
        check_w("stall2", 1'b1, 1'b0, 5'd13, 32'd0, 32'h0000_301c, 32'd11);

        @(negedge clk);
        bus.Flush = 1'b1;
        step();
        check_w("stall_flush", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd11);

        @(negedge clk);
        bus.Stall = 1'b0;
        bus.Flush = 1'b0;
        step();
        check_w("resume", 1'b1, 1'b1, 5'd20, 32'h5555_5555, 32'h0000_3040, 32'd12);

        @(negedge clk);
        bus.Flush = 1'b1;
        step();
        check_w("flush_only", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd12);

        @(negedge clk);
        bus.Flush = 1'b0;
        step();
        @(negedge clk);
        drive_m(1'b0, 32'h0000_3050, 1'b1, 5'd21, 32'h7777_7777, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        check_w("mvalid0", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd13);

        // Reset in the middle of a stall clears everything at once
        @(negedge clk);
        drive_m(1'b1, 32'h0000_3060, 1'b1, 5'd22, 32'h8888_8888, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        @(negedge clk);
        bus.Stall = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check_w("async_rst", 1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_3000, 32'd0);

        @(negedge clk);
        reset = 1'b1;
        bus.Stall = 1'b0;
        step();
        check_w("after_rst", 1'b1, 1'b1, 5'd22, 32'h8888_8888, 32'h0000_3060, 32'd1);

        // Retired counter wrap: hold the counter at all-ones across a stalled edge
        @(negedge clk);
        bus.Stall = 1'b1;
        force dut.retired_q = 32'hFFFF_FFFF;
        step();
        @(negedge clk);
        release dut.retired_q;
        #1;
        check("preload", bus.W_Retired, 32'hFFFF_FFFF);
        bus.Stall = 1'b0;
        drive_m(1'b1, 32'h0000_3070, 1'b1, 5'd2, 32'h0000_0042, MEMW, 2'd0, 3'd0, 2'd0);
        step();
        check("wrap", bus.W_Retired, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
